// File: rtl/regfile_sb.sv
// regfile_sb: multi-port register file with a per-register pending-write
// scoreboard and an incrementally maintained pending counter.
//
// Configuration macro: REGFILE_BYPASS_EN
//   defined   -> same-cycle write-through forwarding on every read port
//                (port 1 beats port 0), ReadReady asserted for forwarded reads
//   undefined -> reads return stored values; ReadReady follows the pending bit
//
// Ports:
//   clk, reset                          clock, synchronous active-high reset
//   ReadRegister / ReadData / ReadReady NUM_RD packed read ports (address,
//                                       combinational data, ready flag)
//   RegWrite{0,1}, WriteRegister{0,1},
//   WriteData{0,1}                      two write ports, port 1 wins on collision
//   Reserve, ReserveRegister            mark a register pending (issue)
//   PendingCount                        registered count of pending registers
module regfile_sb #(
    parameter  int unsigned WIDTH    = 64,
    parameter  int unsigned DEPTH    = 32,
    parameter  int unsigned NUM_RD   = 2,
    parameter  int unsigned ZERO_REG = DEPTH - 1,
    localparam int unsigned AW       = $clog2(DEPTH)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_RD*AW-1:0]    ReadRegister,
    output logic [NUM_RD*WIDTH-1:0] ReadData,
    output logic [NUM_RD-1:0]       ReadReady,
    input  logic                    RegWrite0,
    input  logic                    RegWrite1,
    input  logic [AW-1:0]           WriteRegister0,
    input  logic [AW-1:0]           WriteRegister1,
    input  logic [WIDTH-1:0]        WriteData0,
    input  logic [WIDTH-1:0]        WriteData1,
    input  logic                    Reserve,
    input  logic [AW-1:0]           ReserveRegister,
    output logic [AW:0]             PendingCount
);

    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [DEPTH-1:0] r_pending;
    logic [CW-1:0]    r_count;

    logic             w_we0;
    logic             w_we1;
    logic             w_rsv;
    logic [DEPTH-1:0] w_pend_nxt;
    logic             w_inc;
    logic             w_dec0;
    logic             w_dec1;
    logic [CW-1:0]    w_count_nxt;

    // Address names a real, writable register (in range and not the zero reg).
    function automatic logic f_live(input logic [AW-1:0] a);
        return (32'(a) < DEPTH) && (a != AW'(ZERO_REG));
    endfunction

    assign w_we0 = RegWrite0 && f_live(WriteRegister0);
    assign w_we1 = RegWrite1 && f_live(WriteRegister1);
    assign w_rsv = Reserve   && f_live(ReserveRegister);

    // Next pending vector: writes clear, then reserve sets (reserve wins).
    always_comb begin
        w_pend_nxt = r_pending;
        if (w_we0) w_pend_nxt[WriteRegister0] = 1'b0;
        if (w_we1) w_pend_nxt[WriteRegister1] = 1'b0;
        if (w_rsv) w_pend_nxt[ReserveRegister] = 1'b1;
    end

    // Counter delta: at most one bit set, each distinct written pending bit
    // that is not re-reserved this cycle gets cleared.
    always_comb begin
        w_inc  = w_rsv && !r_pending[ReserveRegister];
        w_dec0 = w_we0 && r_pending[WriteRegister0]
                 && !(w_rsv && (ReserveRegister == WriteRegister0));
        w_dec1 = w_we1 && r_pending[WriteRegister1]
                 && !(w_rsv && (ReserveRegister == WriteRegister1))
                 && !(w_we0 && (WriteRegister0 == WriteRegister1));
        w_count_nxt = r_count + CW'(w_inc) - CW'(w_dec0) - CW'(w_dec1);
    end

    // Storage, scoreboard and counter state.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < int'(DEPTH); i++) r_mem[i] <= '0;
            r_pending <= '0;
            r_count   <= '0;
        end else begin
            if (w_we0) r_mem[WriteRegister0] <= WriteData0;
            if (w_we1) r_mem[WriteRegister1] <= WriteData1;
            r_pending <= w_pend_nxt;
            r_count   <= w_count_nxt;
        end
    end

    assign PendingCount = r_count;

    // Independent read mux per port.
    for (genvar g = 0; g < int'(NUM_RD); g++) begin : g_rd
        logic [AW-1:0]    w_addr;
        logic             w_live;
        logic [WIDTH-1:0] w_data;
        logic             w_rdy;

        assign w_addr = ReadRegister[g*AW +: AW];
        assign w_live = f_live(w_addr);

        always_comb begin
            w_data = '0;
            w_rdy  = 1'b1;
            if (w_live) begin
                w_data = r_mem[w_addr];
                w_rdy  = !r_pending[w_addr];
            end
`ifdef REGFILE_BYPASS_EN
            // w_we* already excludes the zero reg, so a match implies w_live.
            if (w_we1 && (WriteRegister1 == w_addr)) begin
                w_data = WriteData1;
                w_rdy  = 1'b1;
            end else if (w_we0 && (WriteRegister0 == w_addr)) begin
                w_data = WriteData0;
                w_rdy  = 1'b1;
            end
`endif
        end

        assign ReadData[g*WIDTH +: WIDTH] = w_data;
        assign ReadReady[g]               = w_rdy;
    end

endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: directed scenarios plus randomized traffic against an
// array-based reference model of the register file and scoreboard.
module tb_regfile_sb;

    localparam int unsigned W  = 64;
    localparam int unsigned D  = 32;
    localparam int unsigned NR = 2;
    localparam int unsigned AW = 5;
    localparam int unsigned ZR = D - 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              reset;
    logic [NR*AW-1:0]  ReadRegister;
    logic [NR*W-1:0]   ReadData;
    logic [NR-1:0]     ReadReady;
    logic              RegWrite0, RegWrite1;
    logic [AW-1:0]     WriteRegister0, WriteRegister1;
    logic [W-1:0]      WriteData0, WriteData1;
    logic              Reserve;
    logic [AW-1:0]     ReserveRegister;
    logic [AW:0]       PendingCount;

    regfile_sb #(.WIDTH(W), .DEPTH(D), .NUM_RD(NR), .ZERO_REG(ZR)) u_dut (
        .clk            (clk),
        .reset          (reset),
        .ReadRegister   (ReadRegister),
        .ReadData       (ReadData),
        .ReadReady      (ReadReady),
        .RegWrite0      (RegWrite0),
        .RegWrite1      (RegWrite1),
        .WriteRegister0 (WriteRegister0),
        .WriteRegister1 (WriteRegister1),
        .WriteData0     (WriteData0),
        .WriteData1     (WriteData1),
        .Reserve        (Reserve),
        .ReserveRegister(ReserveRegister),
        .PendingCount   (PendingCount)
    );

    // Reference state
    logic [W-1:0] m_mem  [D];
    bit           m_pend [D];

    int n_cmp = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_read(input logic [AW-1:0] a, output logic [W-1:0] d, output logic r);
        d = '0;
        r = 1'b1;
        if (a != AW'(ZR)) begin
            d = m_mem[a];
            r = !m_pend[a];
`ifdef REGFILE_BYPASS_EN
            if (RegWrite1 && WriteRegister1 == a) begin
                d = WriteData1;
                r = 1'b1;
            end else if (RegWrite0 && WriteRegister0 == a) begin
                d = WriteData0;
                r = 1'b1;
            end
`endif
        end
    endtask

    task automatic model_edge();
        if (reset) begin
            for (int i = 0; i < int'(D); i++) begin
                m_mem[i]  = '0;
                m_pend[i] = 1'b0;
            end
        end else begin
            if (RegWrite0 && WriteRegister0 != AW'(ZR)) m_mem[WriteRegister0] = WriteData0;
            if (RegWrite1 && WriteRegister1 != AW'(ZR)) m_mem[WriteRegister1] = WriteData1;
            if (RegWrite0) m_pend[WriteRegister0] = 1'b0;
            if (RegWrite1) m_pend[WriteRegister1] = 1'b0;
            if (Reserve && ReserveRegister != AW'(ZR)) m_pend[ReserveRegister] = 1'b1;
        end
    endtask

    // One clock: check reads with current inputs, clock, check counter.
    task automatic step();
        logic [W-1:0] ed;
        logic         er;
        int           c;
        #1;
        for (int k = 0; k < int'(NR); k++) begin
            model_read(ReadRegister[k*AW +: AW], ed, er);
            check_eq("rd_data", ReadData[k*W +: W], ed);
            check_eq("rd_ready", W'(ReadReady[k]), W'(er));
        end
        @(posedge clk);
        model_edge();
        #1;
        c = 0;
        for (int i = 0; i < int'(D); i++) c += int'(m_pend[i]);
        check_eq("pend_cnt", W'(PendingCount), W'(c));
    endtask

    task automatic idle();
        reset           = 1'b0;
        RegWrite0       = 1'b0;
        RegWrite1       = 1'b0;
        WriteRegister0  = '0;
        WriteRegister1  = '0;
        WriteData0      = '0;
        WriteData1      = '0;
        Reserve         = 1'b0;
        ReserveRegister = '0;
    endtask

    task automatic rd(input int a0, input int a1);
        ReadRegister = {AW'(a1), AW'(a0)};
    endtask

    task automatic reserve(input int a);
        idle();
        Reserve = 1'b1;
        ReserveRegister = AW'(a);
        step();
    endtask

    initial begin
        for (int i = 0; i < int'(D); i++) begin
            m_mem[i]  = {$urandom, $urandom};
            m_pend[i] = 1'b0;
        end
        idle();
        rd(0, 1);
        reset = 1'b1;
        @(posedge clk);
        model_edge();
        #1;
        step();

        // All registers read zero and ready after reset
        idle();
        for (int i = 0; i < int'(D); i += 2) begin
            rd(i, i + 1);
            step();
        end
        check_eq("reset_cnt", W'(PendingCount), '0);

        // Write X5 while reading it
        idle();
        rd(5, 5);
        RegWrite0 = 1'b1; WriteRegister0 = 5; WriteData0 = 64'hDEAD_BEEF;
        step();
        idle();
        #1;
        check_eq("x5_next", ReadData[W-1:0], 64'hDEAD_BEEF);
        step();

        // Both ports write X7; port 1 wins
        rd(7, 7);
        RegWrite0 = 1'b1; WriteRegister0 = 7; WriteData0 = 64'h1;
        RegWrite1 = 1'b1; WriteRegister1 = 7; WriteData1 = 64'h2;
        step();
        idle();
        #1;
        check_eq("x7_p1_wins", ReadData[W-1:0], 64'h2);
        step();

        // Zero register: write and reserve ignored
        rd(ZR, ZR);
        RegWrite0 = 1'b1; WriteRegister0 = AW'(ZR); WriteData0 = 64'hFFFF;
        Reserve = 1'b1; ReserveRegister = AW'(ZR);
        step();
        idle();
        #1;
        check_eq("zero_data", ReadData[W-1:0], '0);
        check_eq("zero_ready", W'(ReadReady[0]), 64'h1);
        check_eq("zero_cnt", W'(PendingCount), '0);
        step();

        // Scoreboard counting
        rd(3, 4);
        reserve(3); check_eq("cnt_r3", W'(PendingCount), 64'd1);
        reserve(4); check_eq("cnt_r4", W'(PendingCount), 64'd2);
        reserve(3); check_eq("cnt_r3_again", W'(PendingCount), 64'd2);
        idle();
        RegWrite0 = 1'b1; WriteRegister0 = 3; WriteData0 = 64'h33;
        Reserve = 1'b1; ReserveRegister = 4;
        step();
        check_eq("cnt_w3_r4", W'(PendingCount), 64'd1);
        idle();
        #1;
        check_eq("x3_ready", W'(ReadReady[0]), 64'h1);
        check_eq("x4_pending", W'(ReadReady[1]), 64'h0);
        RegWrite0 = 1'b1; WriteRegister0 = 4; WriteData0 = 64'h44;
        Reserve = 1'b1; ReserveRegister = 4;
        step();
        check_eq("cnt_w4_r4", W'(PendingCount), 64'd1);
        idle();
        #1;
        check_eq("x4_still_pending", W'(ReadReady[1]), 64'h0);

        // Reset with three pending and a write in flight
        reserve(10);
        reserve(11);
        check_eq("cnt_three", W'(PendingCount), 64'd3);
        idle();
        rd(12, 4);
        reset = 1'b1;
        RegWrite0 = 1'b1; WriteRegister0 = 12; WriteData0 = 64'hABCD;
        step();
        idle();
        #1;
        check_eq("rst_cnt", W'(PendingCount), '0);
        check_eq("rst_drop_write", ReadData[W-1:0], '0);
        check_eq("rst_x4_data", ReadData[2*W-1:W], '0);
        check_eq("rst_ready", W'(ReadReady), 64'h3);
        step();

        // Randomized traffic, addresses biased to a small set for collisions
        for (int n = 0; n < 800; n++) begin
            reset           = ($urandom_range(0, 79) == 0);
            rd($urandom_range(0, 3) == 0 ? $urandom_range(0, 31) : $urandom_range(0, 7),
               $urandom_range(0, 3) == 0 ? int'(ZR) : $urandom_range(0, 7));
            RegWrite0       = ($urandom_range(0, 2) == 0);
            RegWrite1       = ($urandom_range(0, 2) == 0);
            WriteRegister0  = AW'($urandom_range(0, 7));
            WriteRegister1  = ($urandom_range(0, 7) == 0) ? AW'(ZR) : AW'($urandom_range(0, 7));
            WriteData0      = {$urandom, $urandom};
            WriteData1      = {$urandom, $urandom};
            Reserve         = ($urandom_range(0, 1) == 0);
            ReserveRegister = ($urandom_range(0, 9) == 0) ? AW'(ZR) : AW'($urandom_range(0, 7));
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
